// File: rtl/d_cache_wt_if.sv
// Bus bundle between the memory stage, the d_cache_wt cache and the data SRAM port.
// master = datapath/SRAM side that drives requests and read data; slave = the cache.
interface d_cache_wt_if;
    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        stall;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_en, data_wen, data_addr, data_wdata, data_sram_rdata,
        input  data_rdata, stall, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

    modport slave (
        input  data_en, data_wen, data_addr, data_wdata, data_sram_rdata,
        output data_rdata, stall, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/d_cache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with multi-cycle SRAM reads.
// Define DCACHE_STATS_EN to add hit_cnt_o/miss_cnt_o read hit/miss counters.
module d_cache_wt #(
    parameter int unsigned INDEX_W  = 6,
    parameter int unsigned SRAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    d_cache_wt_if.slave   bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]   hit_cnt_o,
    output logic [31:0]   miss_cnt_o
`endif
);
    localparam int unsigned Lines = 1 << INDEX_W;
    localparam int unsigned TagW  = 30 - INDEX_W;
    localparam int unsigned CntW  = $clog2(SRAM_LAT + 1);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StResp, StWr} state_e;

    state_e                state_q;
    logic [Lines-1:0]      valid_q;
    logic [TagW-1:0]       tag_q  [Lines];
    logic [31:0]           line_q [Lines];
    logic [29:0]           addr_q;
    logic [3:0]            wen_q;
    logic [31:0]           wdata_q;
    logic                  hit_q;
    logic [CntW-1:0]       cnt_q;
    logic [31:0]           resp_q;
    logic                  sram_en_q;
    logic [3:0]            sram_wen_q;
    logic [31:0]           sram_addr_q;
    logic [31:0]           sram_wdata_q;

    logic [INDEX_W-1:0]    req_idx, idx_q;
    logic [TagW-1:0]       req_tag;
    logic                  hit, is_wr, stall;
    logic [31:0]           rdata, merged;
    logic                  unused_addr;

    assign req_idx     = bus.data_addr[INDEX_W+1:2];
    assign req_tag     = bus.data_addr[31:INDEX_W+2];
    assign idx_q       = addr_q[INDEX_W-1:0];
    assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign is_wr       = |bus.data_wen;
    assign unused_addr = ^bus.data_addr[1:0];

    // Outputs are gated by rst so an asynchronous abort drops stall immediately.
    always_comb begin
        stall = 1'b0;
        rdata = '0;
        if (!rst) begin
            case (state_q)
                StIdle: begin
                    if (bus.data_en) begin
                        if (is_wr || !hit) stall = 1'b1;
                        else               rdata = line_q[req_idx];
                    end
                end
                StReq, StWait: stall = 1'b1;
                StResp:        rdata = resp_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        merged = line_q[idx_q];
        for (int b = 0; b < 4; b++) begin
            if (wen_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            addr_q       <= '0;
            wen_q        <= '0;
            wdata_q      <= '0;
            hit_q        <= 1'b0;
            cnt_q        <= '0;
            resp_q       <= '0;
            sram_en_q    <= 1'b0;
            sram_wen_q   <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
`ifdef DCACHE_STATS_EN
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
`endif
        end else begin
            // SRAM outputs live for exactly one cycle (REQ or WR) per access.
            sram_en_q    <= 1'b0;
            sram_wen_q   <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            case (state_q)
                StIdle: begin
                    if (bus.data_en) begin
                        addr_q  <= bus.data_addr[31:2];
                        wen_q   <= bus.data_wen;
                        wdata_q <= bus.data_wdata;
                        hit_q   <= hit;
                        if (is_wr) begin
                            state_q      <= StWr;
                            sram_en_q    <= 1'b1;
                            sram_wen_q   <= bus.data_wen;
                            sram_addr_q  <= {bus.data_addr[31:2], 2'b00};
                            sram_wdata_q <= bus.data_wdata;
                        end else if (!hit) begin
                            state_q     <= StReq;
                            sram_en_q   <= 1'b1;
                            sram_addr_q <= {bus.data_addr[31:2], 2'b00};
`ifdef DCACHE_STATS_EN
                            miss_cnt_o  <= miss_cnt_o + 32'd1;
`endif
                        end else begin
`ifdef DCACHE_STATS_EN
                            hit_cnt_o   <= hit_cnt_o + 32'd1;
`endif
                        end
                    end
                end
                StReq: begin
                    cnt_q   <= CntW'(SRAM_LAT - 1);
                    state_q <= StWait;
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        valid_q[idx_q] <= 1'b1;
                        resp_q         <= bus.data_sram_rdata;
                        state_q        <= StResp;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StResp:  state_q <= StIdle;
                StWr:    state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag/data storage needs no reset; valid_q guards every use.
    always_ff @(posedge clk) begin
        if (state_q == StWait && cnt_q == '0) begin
            tag_q[idx_q]  <= addr_q[29:INDEX_W];
            line_q[idx_q] <= bus.data_sram_rdata;
        end else if (state_q == StWr && hit_q) begin
            line_q[idx_q] <= merged;
        end
    end

    assign bus.stall           = stall;
    assign bus.data_rdata      = rdata;
    assign bus.data_sram_en    = sram_en_q;
    assign bus.data_sram_wen   = sram_wen_q;
    assign bus.data_sram_addr  = sram_addr_q;
    assign bus.data_sram_wdata = sram_wdata_q;
endmodule

// File: tb/tb_d_cache_wt.sv
// Randomised self-checking bench for d_cache_wt: behavioural SRAM plus a line-ownership
// cache model; with DCACHE_STATS_EN the hit/miss counters are also scored.
module tb_d_cache_wt;
    parameter int unsigned INDEX_W  = 6;
    parameter int unsigned SRAM_LAT = 1;
    localparam int unsigned Lines   = 1 << INDEX_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    d_cache_wt_if bus ();
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    d_cache_wt #(.INDEX_W(INDEX_W), .SRAM_LAT(SRAM_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned w);
        return w * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wen);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (wen[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Behavioural SRAM, driven only by what the DUT actually issues.
    logic [31:0] sram_mem [int unsigned];
    typedef struct { int unsigned due; logic [31:0] data; } rd_t;
    rd_t pend[$];
    int unsigned cyc = 0;
    int unsigned n_rd = 0, n_wr = 0;
    logic [31:0] last_rd_addr, last_wr_addr, last_wr_wdata;
    logic [3:0]  last_wr_wen;

    function automatic logic [31:0] sram_rd(input int unsigned w);
        return sram_mem.exists(w) ? sram_mem[w] : init_word(w);
    endfunction

    initial begin
        bus.data_sram_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend.size() != 0 && pend[0].due == cyc) begin
                bus.data_sram_rdata = pend[0].data;
                void'(pend.pop_front());
            end else begin
                bus.data_sram_rdata = $urandom;
            end
            if (bus.data_sram_en) begin
                if (bus.data_sram_wen == 4'b0) begin
                    rd_t e;
                    e.due  = cyc + SRAM_LAT;
                    e.data = sram_rd(bus.data_sram_addr >> 2);
                    pend.push_back(e);
                    n_rd++;
                    last_rd_addr = bus.data_sram_addr;
                end else begin
                    sram_mem[bus.data_sram_addr >> 2] =
                        merge(sram_rd(bus.data_sram_addr >> 2), bus.data_sram_wdata,
                              bus.data_sram_wen);
                    n_wr++;
                    last_wr_addr  = bus.data_sram_addr;
                    last_wr_wen   = bus.data_sram_wen;
                    last_wr_wdata = bus.data_sram_wdata;
                end
            end else begin
                check("sram_idle_zero",
                      {28'b0, bus.data_sram_wen} | bus.data_sram_addr | bus.data_sram_wdata,
                      32'b0);
            end
        end
    end

    // Reference model: which word each line holds, and what memory should contain.
    logic [31:0] ref_mem [int unsigned];
    bit          m_valid [Lines];
    int unsigned m_word  [Lines];
    int unsigned m_hits = 0, m_misses = 0;

    function automatic logic [31:0] ref_rd(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    task automatic invalidate_model();
        for (int i = 0; i < Lines; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic do_access(input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata);
        int unsigned w   = addr >> 2;
        int unsigned idx = w % Lines;
        bit          is_hit = m_valid[idx] && m_word[idx] == w;
        int unsigned exp_stall = (wen != 0) ? 1 : (is_hit ? 0 : 2 + SRAM_LAT);
        int unsigned rd0 = n_rd, wr0 = n_wr, stalls = 0;
        bit          done = 1'b0;
        logic [31:0] got = '0;

        @(posedge clk); #1;
        bus.data_en = 1'b1; bus.data_wen = wen; bus.data_addr = addr; bus.data_wdata = wdata;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (!bus.stall) begin
                done = 1'b1;
                got  = bus.data_rdata;
            end else begin
                stalls++;
            end
        end
        @(posedge clk); #1;
        bus.data_en = 1'b0; bus.data_wen = '0; bus.data_addr = '0; bus.data_wdata = '0;

        check("completed", 32'(done), 32'd1);
        check("stall_cycles", stalls, exp_stall);
        if (wen == 0) begin
            check("rdata", got, ref_rd(w));
            check("sram_rd_ops", n_rd - rd0, is_hit ? 0 : 1);
            check("sram_wr_ops_on_read", n_wr - wr0, 0);
            if (!is_hit) begin
                check("sram_rd_addr", last_rd_addr, {addr[31:2], 2'b00});
                m_valid[idx] = 1'b1;
                m_word[idx]  = w;
                m_misses++;
            end else begin
                m_hits++;
            end
        end else begin
            check("sram_wr_ops", n_wr - wr0, 1);
            check("sram_rd_ops_on_write", n_rd - rd0, 0);
            check("sram_wr_addr", last_wr_addr, {addr[31:2], 2'b00});
            check("sram_wr_wen", {28'b0, last_wr_wen}, {28'b0, wen});
            check("sram_wr_wdata", last_wr_wdata, wdata);
            ref_mem[w] = merge(ref_rd(w), wdata, wen);
        end
    endtask

    int unsigned tags [4];

    initial begin
        bus.data_en = 1'b0; bus.data_wen = '0; bus.data_addr = '0; bus.data_wdata = '0;
        invalidate_model();
        sram_mem[32'h1000 >> 2] = 32'hDEADBEEF;
        ref_mem[32'h1000 >> 2]  = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        check("reset_stall", {31'b0, bus.stall}, 32'b0);
        check("reset_rdata", bus.data_rdata, 32'b0);
        check("reset_sram_en", {31'b0, bus.data_sram_en}, 32'b0);
`ifdef DCACHE_STATS_EN
        check("reset_hit_cnt", hit_cnt, 32'b0);
        check("reset_miss_cnt", miss_cnt, 32'b0);
`endif
        rst = 1'b0;

        do_access(4'b0000, 32'h0000_1000, 32'h0);
        do_access(4'b0000, 32'h0000_1000, 32'h0);
        do_access(4'b0100, 32'h0000_1002, 32'h00AB_0000);
        do_access(4'b0000, 32'h0000_1000, 32'h0);
        check("merged_word", ref_rd(32'h1000 >> 2), 32'hDEABBEEF);
        do_access(4'b1111, 32'h0000_2000, 32'h1357_9BDF);
        do_access(4'b0000, 32'h0000_2000, 32'h0);
        do_access(4'b0000, 32'h0000_1000 + (32'd1 << (INDEX_W + 2)), 32'h0);
        do_access(4'b0000, 32'h0000_1000, 32'h0);
        do_access(4'b0000, 32'hFFFF_FFFC, 32'h0);
        do_access(4'b0011, 32'hFFFF_FFFD, 32'hCAFE_F00D);
        do_access(4'b0000, 32'hFFFF_FFFE, 32'h0);

        tags[0] = 0;
        tags[1] = 1;
        tags[2] = 32'h55;
        tags[3] = (1 << (30 - INDEX_W)) - 1;
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            logic [3:0]  wen;
            a = (tags[$urandom_range(0, 3)] << (INDEX_W + 2)) |
                ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            wen = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            do_access(wen, a, $urandom);
        end

`ifdef DCACHE_STATS_EN
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_misses);
`endif

        // Abort a cold read miss while it waits on the SRAM.
        @(posedge clk); #1;
        bus.data_en = 1'b1; bus.data_wen = '0; bus.data_addr = 32'h3000_0000;
        repeat (2) @(posedge clk);
        #1;
        check("abort_in_wait_stall", {31'b0, bus.stall}, 32'b1);
        rst = 1'b1;
        #1;
        check("abort_stall", {31'b0, bus.stall}, 32'b0);
        check("abort_sram_en", {31'b0, bus.data_sram_en}, 32'b0);
        check("abort_sram_addr", bus.data_sram_addr, 32'b0);
        check("abort_rdata", bus.data_rdata, 32'b0);
        bus.data_en = 1'b0; bus.data_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        invalidate_model();
`ifdef DCACHE_STATS_EN
        check("abort_hit_cnt", hit_cnt, 32'b0);
        check("abort_miss_cnt", miss_cnt, 32'b0);
`endif
        do_access(4'b0000, 32'h0000_1000, 32'h0);
        do_access(4'b0000, 32'h0000_1000, 32'h0);
`ifdef DCACHE_STATS_EN
        check("final_hit_cnt", hit_cnt, m_hits);
        check("final_miss_cnt", miss_cnt, m_misses);
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
